// File: rtl/sub_matrix_seq_if.sv
// Bus bundle for sub_matrix_seq: matrix in/out handshakes, key-schedule port, shared S-box link.
// SUB_MATRIX_SEQ_STALL_CNT_EN adds the StallCnt_DO preemption counter.
interface sub_matrix_seq_if;
  logic [127:0] MatIn_DI;
  logic         MatInValid_SI;
  logic         MatInReady_SO;
  logic [127:0] MatOut_DO;
  logic         MatOutValid_SO;
  logic         MatOutReady_SI;
  logic [31:0]  KeyWordIn_DI;
  logic         KeyReq_SI;
  logic         KeyGnt_SO;
  logic [31:0]  KeyWordOut_DO;
  logic         KeyValid_SO;
  logic [31:0]  SboxIn_DO;
  logic [31:0]  SboxOut_DI;
`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
  logic [15:0]  StallCnt_DO;
`endif

  modport slave (
    input  MatIn_DI, MatInValid_SI, MatOutReady_SI, KeyWordIn_DI, KeyReq_SI, SboxOut_DI,
`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
    output StallCnt_DO,
`endif
    output MatInReady_SO, MatOut_DO, MatOutValid_SO, KeyGnt_SO, KeyWordOut_DO, KeyValid_SO,
    output SboxIn_DO
  );

  modport master (
    output MatIn_DI, MatInValid_SI, MatOutReady_SI, KeyWordIn_DI, KeyReq_SI, SboxOut_DI,
`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
    input  StallCnt_DO,
`endif
    input  MatInReady_SO, MatOut_DO, MatOutValid_SO, KeyGnt_SO, KeyWordOut_DO, KeyValid_SO,
    input  SboxIn_DO
  );
endinterface

// File: rtl/sub_matrix_seq.sv
// Serialised SubBytes: one shared subWord S-box, key-schedule priority with bounded preemption.
// Optional macro SUB_MATRIX_SEQ_STALL_CNT_EN enables the saturating preemption counter StallCnt_DO.
module sub_matrix_seq #(
  parameter int unsigned KEY_MAX_CONSEC = 2
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  sub_matrix_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;

  localparam logic [3:0] LP_KMAX = 4'(KEY_MAX_CONSEC);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0][31:0]  r_work;
  logic [1:0]        r_wcnt;
  logic [3:0]        r_kcnt;
  logic [31:0]       r_key_out;
  logic              r_key_valid;
  logic              w_key_gnt;
  logic              w_mat_slot;
  logic              w_mat_in_ready;
  logic              w_accept;
  logic [31:0]       w_sbox_in;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Reset gates both handshakes so nothing is granted or accepted in a reset cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_key_gnt      = 1'b0;
    w_mat_slot     = 1'b0;
    w_mat_in_ready = 1'b0;
    w_sbox_in      = '0;
    if (!Rst_RI) begin
      case (r_state)
        S_IDLE: begin
          w_mat_in_ready = 1'b1;
          w_key_gnt      = bus.KeyReq_SI;
          if (bus.MatInValid_SI) w_state_nxt = S_SUB;
        end
        S_SUB: begin
          w_key_gnt  = bus.KeyReq_SI && (r_kcnt < LP_KMAX);
          w_mat_slot = !w_key_gnt;
          if (w_mat_slot && (r_wcnt == 2'd3)) w_state_nxt = S_DONE;
        end
        S_DONE: begin
          w_key_gnt = bus.KeyReq_SI;
          if (bus.MatOutReady_SI) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_key_gnt)       w_sbox_in = bus.KeyWordIn_DI;
      else if (w_mat_slot) w_sbox_in = r_work[r_wcnt];
    end
  end

  assign w_accept = w_mat_in_ready && bus.MatInValid_SI;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_work      <= '0;
      r_wcnt      <= '0;
      r_kcnt      <= '0;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= w_key_gnt;
      if (w_key_gnt) r_key_out <= bus.SboxOut_DI;
      if (w_accept) begin
        r_work <= bus.MatIn_DI;
        r_wcnt <= '0;
        r_kcnt <= '0;
      end
      if (r_state == S_SUB) begin
        if (w_key_gnt) begin
          r_kcnt <= r_kcnt + 4'd1;
        end else begin
          r_work[r_wcnt] <= bus.SboxOut_DI;
          r_wcnt         <= r_wcnt + 2'd1;
          r_kcnt         <= '0;
        end
      end
    end
  end

`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_stall <= '0;
    end else if ((r_state == S_SUB) && w_key_gnt && (r_stall != '1)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign bus.StallCnt_DO = r_stall;
`endif

  assign bus.MatInReady_SO  = w_mat_in_ready;
  assign bus.MatOut_DO      = r_work;
  assign bus.MatOutValid_SO = (r_state == S_DONE);
  assign bus.KeyGnt_SO      = w_key_gnt;
  assign bus.KeyWordOut_DO  = r_key_out;
  assign bus.KeyValid_SO    = r_key_valid;
  assign bus.SboxIn_DO      = w_sbox_in;

endmodule

// File: tb/tb_sub_matrix_seq.sv
// Bench for sub_matrix_seq: vector table, directed corner sequences and a randomized run
// checked against a transaction-level model with an arithmetic AES S-box.
module tb_sub_matrix_seq;
  localparam int KMC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sub_matrix_seq_if bus ();
  sub_matrix_seq_if bus1 ();

  sub_matrix_seq #(.KEY_MAX_CONSEC(KMC)) dut  (.Clk_CI(clk), .Rst_RI(rst), .bus(bus));
  sub_matrix_seq #(.KEY_MAX_CONSEC(1))   dut1 (.Clk_CI(clk), .Rst_RI(rst), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  // S-box = affine(x^254) in GF(2^8)
  function automatic logic [7:0] sbox_b(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] bs;
    int e;
    r  = 8'h01;
    bs = x;
    e  = 254;
    while (e > 0) begin
      if ((e & 1) != 0) r = gmul(r, bs);
      bs = gmul(bs, bs);
      e  = e >> 1;
    end
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sbox_w(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_b(w[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] sbox_m(input logic [127:0] m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_b(m[8*i +: 8]);
    return r;
  endfunction

  always_comb bus.SboxOut_DI  = sbox_w(bus.SboxIn_DO);
  always_comb bus1.SboxOut_DI = sbox_w(bus1.SboxIn_DO);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of the main instance, advanced once per cycle at the falling edge.
  logic         mon_en = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_out = 1'b0;
  int           m_left = 0;
  int           m_consec = 0;
  logic         m_kvalid = 1'b0;
  logic [31:0]  m_kword = '0;
  logic [127:0] m_mat = '0;
  logic         e_rdy;
  logic         e_gnt;
`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
  logic [15:0]  m_stall = '0;
`endif

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("mon_out_valid", 128'(bus.MatOutValid_SO), 128'(m_out));
        if (m_out) chk("mon_out_data", bus.MatOut_DO, m_mat);
        chk("mon_key_valid", 128'(bus.KeyValid_SO), 128'(m_kvalid));
        chk("mon_key_word", 128'(bus.KeyWordOut_DO), 128'(m_kword));
`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
        chk("mon_stall", 128'(bus.StallCnt_DO), 128'(m_stall));
`endif
        e_rdy = !rst && !m_busy && !m_out;
        e_gnt = !rst && bus.KeyReq_SI && (!m_busy || (m_consec < KMC));
        chk("mon_in_ready", 128'(bus.MatInReady_SO), 128'(e_rdy));
        chk("mon_key_gnt", 128'(bus.KeyGnt_SO), 128'(e_gnt));
        if (e_gnt) chk("mon_sbox_in", 128'(bus.SboxIn_DO), 128'(bus.KeyWordIn_DI));
        if (rst) begin
          m_busy = 1'b0; m_out = 1'b0; m_left = 0; m_consec = 0;
          m_kvalid = 1'b0; m_kword = '0; m_mat = '0;
`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
          m_stall = '0;
`endif
        end else begin
          m_kvalid = e_gnt;
          if (e_gnt) m_kword = sbox_w(bus.KeyWordIn_DI);
          if (m_busy) begin
            if (e_gnt) begin
              m_consec++;
`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
              if (m_stall != 16'hffff) m_stall++;
`endif
            end else begin
              m_left--;
              m_consec = 0;
              if (m_left == 0) begin
                m_busy = 1'b0;
                m_out  = 1'b1;
              end
            end
          end else if (m_out) begin
            if (bus.MatOutReady_SI) m_out = 1'b0;
          end else if (bus.MatInValid_SI) begin
            m_busy = 1'b1; m_left = 4; m_consec = 0;
            m_mat  = sbox_m(bus.MatIn_DI);
          end
        end
      end
    end
  end

  typedef struct {
    logic [127:0] mat;
    int           kcyc;
    logic [31:0]  kword;
    int           dly;
    logic [127:0] exp_mat;
    int           exp_lat;
    logic [31:0]  exp_kw;
    int           exp_stall;
  } vec_t;

  vec_t vt[5];

  task automatic do_mat(input logic [127:0] m, input logic [127:0] e, input int elat);
    int lat;
    bus.MatIn_DI = m;
    bus.MatInValid_SI = 1'b1;
    tick;
    bus.MatInValid_SI = 1'b0;
    lat = 1;
    while (!bus.MatOutValid_SO && lat < 60) begin
      tick;
      lat++;
    end
    chk("plain_latency", 128'(lat), 128'(elat));
    chk("plain_data", bus.MatOut_DO, e);
    bus.MatOutReady_SI = 1'b1;
    tick;
    bus.MatOutReady_SI = 1'b0;
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected self-termination");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        pg;
    logic        eg;
    logic [31:0] pw;
    int          kp;

    vt[0] = '{mat: '0, kcyc: 0, kword: '0, dly: 0, exp_mat: {16{8'h63}},
              exp_lat: 5, exp_kw: '0, exp_stall: 0};
    vt[1] = '{mat: {32'h0, 32'h53535353, 32'h01010101, 32'h0}, kcyc: 0, kword: '0, dly: 3,
              exp_mat: {32'h63636363, 32'hedededed, 32'h7c7c7c7c, 32'h63636363},
              exp_lat: 5, exp_kw: '0, exp_stall: 0};
    vt[2] = '{mat: {32'h10111213, 32'h00010203, 32'h0f0e0d0c, 32'h53535353}, kcyc: 99,
              kword: 32'h01010101, dly: 0,
              exp_mat: {32'hca82c97d, 32'h637c777b, 32'h76abd7fe, 32'hedededed},
              exp_lat: 13, exp_kw: 32'h7c7c7c7c, exp_stall: 8};
    vt[3] = '{mat: {16{8'h53}}, kcyc: 1, kword: 32'h00010203, dly: 2, exp_mat: {16{8'hed}},
              exp_lat: 5, exp_kw: 32'h637c777b, exp_stall: 0};
    vt[4] = '{mat: {16{8'h01}}, kcyc: 99, kword: 32'h0, dly: 1, exp_mat: {16{8'h7c}},
              exp_lat: 13, exp_kw: 32'h63636363, exp_stall: 8};

    rst = 1'b1;
    bus.MatIn_DI = '0;  bus.MatInValid_SI = 1'b1; bus.MatOutReady_SI = 1'b0;
    bus.KeyWordIn_DI = 32'h12345678; bus.KeyReq_SI = 1'b1;
    bus1.MatIn_DI = '0; bus1.MatInValid_SI = 1'b0; bus1.MatOutReady_SI = 1'b0;
    bus1.KeyWordIn_DI = '0; bus1.KeyReq_SI = 1'b0;

    // Reset wins over simultaneous matrix and key requests
    tick;
    mon_en = 1'b1;
    tick;
    chk("rst_in_ready", 128'(bus.MatInReady_SO), 128'(1'b0));
    chk("rst_key_gnt", 128'(bus.KeyGnt_SO), 128'(1'b0));
    chk("rst_out_valid", 128'(bus.MatOutValid_SO), 128'(1'b0));
    chk("rst_key_valid", 128'(bus.KeyValid_SO), 128'(1'b0));
    chk("rst_mat_out", bus.MatOut_DO, 128'h0);
    chk("rst_key_word", 128'(bus.KeyWordOut_DO), 128'h0);
    rst = 1'b0;
    bus.MatInValid_SI = 1'b0;
    bus.KeyReq_SI = 1'b0;
    #1;
    chk("post_rst_ready", 128'(bus.MatInReady_SO), 128'(1'b1));
    tick;

    for (int v = 0; v < 5; v++) begin
      int lat;
`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
      logic [15:0] st0;
      st0 = bus.StallCnt_DO;
`endif
      bus.MatIn_DI = vt[v].mat;
      bus.MatInValid_SI = 1'b1;
      bus.KeyWordIn_DI = vt[v].kword;
      bus.KeyReq_SI = (vt[v].kcyc > 0);
      bus.MatOutReady_SI = 1'b0;
      #1;
      chk("tbl_accept_ready", 128'(bus.MatInReady_SO), 128'(1'b1));
      if (vt[v].kcyc > 0) chk("tbl_idle_gnt", 128'(bus.KeyGnt_SO), 128'(1'b1));
      tick;
      bus.MatInValid_SI = 1'b0;
      lat = 1;
      bus.KeyReq_SI = (lat < vt[v].kcyc);
      if (vt[v].kcyc > 0) begin
        chk("tbl_key_valid", 128'(bus.KeyValid_SO), 128'(1'b1));
        chk("tbl_key_word", 128'(bus.KeyWordOut_DO), 128'(vt[v].exp_kw));
      end
      while (!bus.MatOutValid_SO && lat < 60) begin
        tick;
        lat++;
        bus.KeyReq_SI = (lat < vt[v].kcyc);
      end
      bus.KeyReq_SI = 1'b0;
      chk("tbl_latency", 128'(lat), 128'(vt[v].exp_lat));
`ifdef SUB_MATRIX_SEQ_STALL_CNT_EN
      chk("tbl_stall", 128'(bus.StallCnt_DO - st0), 128'(vt[v].exp_stall));
`endif
      for (int d = 0; d < vt[v].dly; d++) begin
        chk("tbl_hold_valid", 128'(bus.MatOutValid_SO), 128'(1'b1));
        chk("tbl_hold_data", bus.MatOut_DO, vt[v].exp_mat);
        tick;
      end
      chk("tbl_data", bus.MatOut_DO, vt[v].exp_mat);
      bus.MatOutReady_SI = 1'b1;
      tick;
      bus.MatOutReady_SI = 1'b0;
      #1;
      chk("tbl_valid_drop", 128'(bus.MatOutValid_SO), 128'(1'b0));
      chk("tbl_back_idle", 128'(bus.MatInReady_SO), 128'(1'b1));
    end

    // Reset after two matrix words, with a key request pending in the reset cycle
    bus.MatIn_DI = {16{8'h01}};
    bus.MatInValid_SI = 1'b1;
    tick;
    bus.MatInValid_SI = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    bus.KeyReq_SI = 1'b1;
    bus.KeyWordIn_DI = 32'h53535353;
    #1;
    chk("midrst_gnt", 128'(bus.KeyGnt_SO), 128'(1'b0));
    tick;
    rst = 1'b0;
    bus.KeyReq_SI = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(bus.MatOutValid_SO), 128'(1'b0));
    chk("midrst_key_valid", 128'(bus.KeyValid_SO), 128'(1'b0));
    chk("midrst_mat_out", bus.MatOut_DO, 128'h0);
    chk("midrst_key_word", 128'(bus.KeyWordOut_DO), 128'h0);
    chk("midrst_ready", 128'(bus.MatInReady_SO), 128'(1'b1));
    do_mat({16{8'h53}}, {16{8'hed}}, 5);
    do_mat('0, {16{8'h63}}, 5);

    // Single-grant limit: strict key/matrix alternation on the second instance
    pg = 1'b0;
    pw = '0;
    bus1.MatIn_DI = {16{8'h53}};
    for (int k = 0; k <= 9; k++) begin
      bus1.KeyWordIn_DI = {4{8'(k)}};
      bus1.KeyReq_SI = (k < 9);
      bus1.MatInValid_SI = (k == 0);
      @(negedge clk);
      eg = (k == 0) ? 1'b1 : ((k < 9) ? ((k % 2) == 1) : 1'b0);
      chk("alt_gnt", 128'(bus1.KeyGnt_SO), 128'(eg));
      chk("alt_out_valid", 128'(bus1.MatOutValid_SO), 128'(k == 9));
      if (k > 0) chk("alt_key_valid", 128'(bus1.KeyValid_SO), 128'(pg));
      if (pg) chk("alt_key_word", 128'(bus1.KeyWordOut_DO), 128'(sbox_w(pw)));
      pg = eg;
      pw = bus1.KeyWordIn_DI;
      tick;
    end
    bus1.KeyReq_SI = 1'b0;
    bus1.MatInValid_SI = 1'b0;
    chk("alt_data", bus1.MatOut_DO, {16{8'hed}});
    bus1.MatOutReady_SI = 1'b1;
    tick;
    bus1.MatOutReady_SI = 1'b0;
    chk("alt_valid_drop", 128'(bus1.MatOutValid_SO), 128'(1'b0));

    // Randomized traffic, key pressure rising per phase, occasional resets
    for (int i = 0; i < 3000; i++) begin
      kp = (i < 1000) ? 20 : ((i < 2000) ? 60 : 95);
      bus.MatIn_DI = {$urandom, $urandom, $urandom, $urandom};
      bus.MatInValid_SI = ($urandom_range(0, 3) == 0);
      bus.KeyReq_SI = ($urandom_range(0, 99) < kp);
      bus.KeyWordIn_DI = $urandom;
      bus.MatOutReady_SI = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 299) == 0);
      tick;
    end
    rst = 1'b0;
    bus.MatInValid_SI = 1'b0;
    bus.KeyReq_SI = 1'b0;
    bus.MatOutReady_SI = 1'b1;
    for (int i = 0; i < 20; i++) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
